// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-bank instruction fetch sequencer.
// Bank 0 holds even halfwords and bank 1 holds odd halfwords.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [15:0] THUMB_NOP    = 16'hBF00;
    localparam logic [15:0] THUMB_B_SELF = 16'hE7FE;

    // IR_0 mux codes; SEL0_IR1 exists in the ROM but the sequencer never selects it.
    localparam logic [1:0] SEL0_BANK0 = 2'd0;
    localparam logic [1:0] SEL0_IR1   = 2'd1;
    localparam logic [1:0] SEL0_BANK1 = 2'd2;

    // First halfword of a 32-bit Thumb instruction: top five bits 11101, 11110 or 11111.
    function automatic logic is_thumb32_prefix(input logic [15:0] hw);
        return (hw[15:13] == 3'b111) && (hw[12:11] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_rom_map.sv
// Maps a halfword fetch address onto the dual-bank ROM index, parity and
// output mux selects so both alignments deliver two consecutive halfwords.
module fetch_rom_map
    import fetch_pkg::*;
#(
    parameter int HADDR_W = 15
) (
    input  logic [HADDR_W-1:0] i_fhpc,
    output logic [HADDR_W-2:0] o_rom_addr,
    output logic               o_pc_1,
    output logic [1:0]         o_sel_mem_0,
    output logic               o_sel_mem_1
);

    logic w_odd;

    assign w_odd       = i_fhpc[0];
    assign o_rom_addr  = i_fhpc[HADDR_W-1:1];
    assign o_pc_1      = w_odd;
    // Odd alignment: first halfword comes from bank 1, second from bank 0 at index+1.
    assign o_sel_mem_0 = w_odd ? SEL0_BANK1 : SEL0_BANK0;
    assign o_sel_mem_1 = ~w_odd;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: tracks the halfword PC, drives the ROM, and
// holds a two-slot issue buffer with Thumb-32 pairing and branch redirects.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                  HADDR_W   = 15,
    parameter logic [HADDR_W-1:0]  RESET_HPC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [HADDR_W-2:0] Rom_addr_in,
    output logic               pc_1,
    output logic               sel_mem_1,
    output logic [1:0]         sel_mem_0,
    input  logic [15:0]        IR_0,
    input  logic [15:0]        IR_1,
    input  logic [1:0]         issue_cnt,
    input  logic               redirect_valid,
    input  logic [HADDR_W-1:0] redirect_hpc,
    output logic [15:0]        ir0,
    output logic [15:0]        ir1,
    output logic               v0,
    output logic               v1,
    output logic               is32,
    output logic [HADDR_W-1:0] buf_hpc,
    output logic               halted,
    output logic               err,
    output fetch_state_e       dbg_state
);

    fetch_state_e       r_state;
    fetch_state_e       w_next_state;
    logic [15:0]        r_ir0;
    logic [15:0]        r_ir1;
    logic [HADDR_W-1:0] r_buf_hpc;
    logic               r_err;

    logic               w_v0;
    logic               w_v1;
    logic               w_is32;
    logic [1:0]         w_len0;
    logic               w_legal;
    logic [1:0]         w_eff_cnt;
    logic               w_hit_b_self;
    logic               w_load;
    logic [HADDR_W-1:0] w_fhpc;

    assign w_v0   = (r_state == RUN);
    assign w_is32 = w_v0 && is_thumb32_prefix(r_ir0);
    // A lone prefix in slot 1 stays invalid and is refetched as slot 0 later.
    assign w_v1   = w_v0 && !w_is32 && !is_thumb32_prefix(r_ir1);
    assign w_len0 = w_is32 ? 2'd2 : 2'd1;

    assign w_legal   = (issue_cnt == 2'd0) ||
                       (w_v0 && ((issue_cnt == w_len0) || (issue_cnt == 2'd2 && w_v1)));
    assign w_eff_cnt = w_legal ? issue_cnt : 2'd0;

    assign w_hit_b_self = ((w_eff_cnt != 2'd0) && (r_ir0 == THUMB_B_SELF)) ||
                          ((w_eff_cnt == 2'd2) && !w_is32 && (r_ir1 == THUMB_B_SELF));

    always_comb begin
        w_fhpc = r_buf_hpc + {{(HADDR_W-2){1'b0}}, w_eff_cnt};
        if (redirect_valid) begin
            w_fhpc = redirect_hpc;
        end else if (r_state == BOOT) begin
            w_fhpc = RESET_HPC;
        end
    end

    // HALT freezes the buffer; in that state w_fhpc already equals the last fetch address.
    assign w_load = redirect_valid || (r_state != HALT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     if (w_hit_b_self) w_next_state = HALT;
            HALT:    w_next_state = HALT;
            default: w_next_state = BOOT;
        endcase
        if (redirect_valid) begin
            w_next_state = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BOOT;
            r_ir0     <= 16'h0000;
            r_ir1     <= 16'h0000;
            r_buf_hpc <= RESET_HPC;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_ir0     <= IR_0;
                r_ir1     <= IR_1;
                r_buf_hpc <= w_fhpc;
            end
            if (!w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    fetch_rom_map #(
        .HADDR_W (HADDR_W)
    ) u_rom_map (
        .i_fhpc      (w_fhpc),
        .o_rom_addr  (Rom_addr_in),
        .o_pc_1      (pc_1),
        .o_sel_mem_0 (sel_mem_0),
        .o_sel_mem_1 (sel_mem_1)
    );

    assign ir0       = r_ir0;
    assign ir1       = r_ir1;
    assign v0        = w_v0;
    assign v1        = w_v1;
    assign is32      = w_is32;
    assign buf_hpc   = r_buf_hpc;
    assign halted    = (r_state == HALT);
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: flat halfword ROM, behavioural fetch model,
// directed scenarios followed by randomized issue/redirect traffic.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int HW = 15;
  localparam int ROM_N = 1 << HW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [HW-2:0] Rom_addr_in;
  logic pc_1, sel_mem_1;
  logic [1:0] sel_mem_0;
  logic [15:0] IR_0, IR_1;
  logic [1:0] issue_cnt = 2'd0;
  logic redirect_valid = 1'b0;
  logic [HW-1:0] redirect_hpc = '0;
  logic [15:0] ir0, ir1;
  logic v0, v1, is32, halted, err;
  logic [HW-1:0] buf_hpc;
  fetch_state_e dbg_state;

  logic [15:0] rom [0:ROM_N-1];
  logic [HW-1:0] rom_hpc;

  int n_checks = 0;
  int n_fail = 0;

  // model state
  bit m_boot, m_halt, m_err;
  logic [HW-1:0] m_buf;
  logic [15:0] m_ir0, m_ir1;

  always #5 clk = ~clk;

  // ROM reassembles the halfword address from index and parity and handles the +1 carry itself.
  assign rom_hpc = {Rom_addr_in, pc_1};
  assign IR_0 = rom[rom_hpc];
  assign IR_1 = rom[rom_hpc + 15'd1];

  fetch_controller #(.HADDR_W(HW), .RESET_HPC('0)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rom_addr_in(Rom_addr_in), .pc_1(pc_1), .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
    .IR_0(IR_0), .IR_1(IR_1),
    .issue_cnt(issue_cnt), .redirect_valid(redirect_valid), .redirect_hpc(redirect_hpc),
    .ir0(ir0), .ir1(ir1), .v0(v0), .v1(v1), .is32(is32),
    .buf_hpc(buf_hpc), .halted(halted), .err(err), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pfx(input logic [15:0] x);
    logic [4:0] top;
    top = x[15:11];
    return top >= 5'd29;
  endfunction

  function automatic bit m_v0();
    return !m_boot && !m_halt;
  endfunction
  function automatic bit m_is32();
    return m_v0() && pfx(m_ir0);
  endfunction
  function automatic bit m_v1();
    return m_v0() && !m_is32() && !pfx(m_ir1);
  endfunction

  function automatic bit m_legal(input logic [1:0] c);
    int len0;
    len0 = m_is32() ? 2 : 1;
    if (c == 0) return 1'b1;
    if (!m_v0()) return 1'b0;
    return (int'(c) == len0) || (c == 2 && m_v1());
  endfunction

  function automatic logic [HW-1:0] m_fhpc();
    int adv;
    adv = m_legal(issue_cnt) ? int'(issue_cnt) : 0;
    if (redirect_valid) return redirect_hpc;
    if (m_boot) return '0;
    return HW'((int'(m_buf) + adv) % ROM_N);
  endfunction

  task automatic model_reset();
    m_boot = 1; m_halt = 0; m_err = 0; m_buf = '0; m_ir0 = '0; m_ir1 = '0;
  endtask

  task automatic model_load(input logic [HW-1:0] a);
    m_ir0 = rom[a];
    m_ir1 = rom[a + 15'd1];
    m_buf = a;
  endtask

  task automatic model_step();
    logic [HW-1:0] f;
    bit hit;
    int adv;
    f = m_fhpc();
    adv = m_legal(issue_cnt) ? int'(issue_cnt) : 0;
    hit = m_v0() && ((adv >= 1 && m_ir0 == THUMB_B_SELF) ||
                     (adv == 2 && !m_is32() && m_ir1 == THUMB_B_SELF));
    if (!m_legal(issue_cnt)) m_err = 1;
    if (redirect_valid) begin
      model_load(redirect_hpc); m_boot = 0; m_halt = 0;
    end else if (!m_halt) begin
      model_load(f); m_boot = 0; m_halt = hit;
    end
  endtask

  task automatic compare_model();
    logic [HW-1:0] f;
    f = m_fhpc();
    chk("rom_addr", 32'(Rom_addr_in), 32'(f >> 1));
    chk("pc_1", 32'(pc_1), 32'(f[0]));
    chk("sel_mem_0", 32'(sel_mem_0), f[0] ? 32'd2 : 32'd0);
    chk("sel_mem_1", 32'(sel_mem_1), f[0] ? 32'd0 : 32'd1);
    chk("ir0", 32'(ir0), 32'(m_ir0));
    chk("ir1", 32'(ir1), 32'(m_ir1));
    chk("v0", 32'(v0), 32'(m_v0()));
    chk("v1", 32'(v1), 32'(m_v1()));
    chk("is32", 32'(is32), 32'(m_is32()));
    chk("buf_hpc", 32'(buf_hpc), 32'(m_buf));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Called at the falling edge: apply inputs, let them settle, compare against the model.
  task automatic drive(input logic [1:0] c, input logic rv, input logic [HW-1:0] rh);
    issue_cnt = c; redirect_valid = rv; redirect_hpc = rh;
    #1;
    compare_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_v0", 32'(v0), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd0);
    chk("rst_buf_hpc", 32'(buf_hpc), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(BOOT));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_image();
    for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;
    rom[0] = 16'hBF00; rom[1] = 16'hBF00; rom[2] = 16'hA001;
    rom[3] = 16'hBF00; rom[4] = 16'hBF00; rom[5] = 16'hE7FE;
  endtask

  function automatic logic [15:0] rand_hw();
    case ($urandom_range(0, 9))
      0, 1:    return 16'hBF00;
      2:       return 16'hA001;
      3:       return 16'hF000;
      4:       return 16'hF800;
      5:       return 16'hE800;
      6:       return ($urandom_range(0, 3) == 0) ? 16'hE7FE : 16'h4770;
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    logic [1:0] c;
    logic [HW-1:0] tgt;
    load_image();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_v0", 32'(v0), 32'd0);
    chk("reset_buf_hpc", 32'(buf_hpc), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(BOOT));
    @(negedge clk);
    rst_n = 1'b1;

    // straight-line fetch to the branch-to-self
    drive(2'd0, 1'b0, '0);
    chk("boot_rom_addr", 32'(Rom_addr_in), 32'd0);
    tick();
    drive(2'd2, 1'b0, '0);
    chk("l_buf0", 32'(buf_hpc), 32'd0);
    chk("l_ir0_0", 32'(ir0), 32'hBF00);
    chk("l_ir1_0", 32'(ir1), 32'hBF00);
    chk("l_v1_0", 32'(v1), 32'd1);
    tick();
    drive(2'd2, 1'b0, '0);
    chk("l_buf2", 32'(buf_hpc), 32'd2);
    chk("l_ir0_2", 32'(ir0), 32'hA001);
    tick();
    drive(2'd2, 1'b0, '0);
    chk("l_buf4", 32'(buf_hpc), 32'd4);
    chk("l_ir1_4", 32'(ir1), 32'hE7FE);
    chk("l_v1_4", 32'(v1), 32'd1);
    tick();
    drive(2'd0, 1'b1, 15'd3);
    chk("l_halted", 32'(halted), 32'd1);
    chk("l_halt_v0", 32'(v0), 32'd0);
    chk("l_halt_state", 32'(dbg_state), 32'(HALT));
    chk("l_redir_addr", 32'(Rom_addr_in), 32'd1);
    chk("l_redir_pc1", 32'(pc_1), 32'd1);
    chk("l_redir_sel0", 32'(sel_mem_0), 32'd2);
    chk("l_redir_sel1", 32'(sel_mem_1), 32'd0);
    tick();
    drive(2'd0, 1'b1, 15'd2);
    chk("l_buf3", 32'(buf_hpc), 32'd3);
    chk("l_ir0_3", 32'(ir0), 32'hBF00);
    chk("l_ir1_3", 32'(ir1), 32'hBF00);
    tick();
    drive(2'd1, 1'b0, '0);
    tick();
    chk("l_issue1_buf", 32'(buf_hpc), 32'd3);
    chk("l_issue1_ir0", 32'(ir0), 32'hBF00);
    repeat (5) begin drive(2'd0, 1'b0, '0); tick(); end
    chk("l_hold_buf", 32'(buf_hpc), 32'd3);
    chk("l_hold_ir0", 32'(ir0), 32'hBF00);

    // Thumb-32 pairing
    rom[0] = 16'hF000; rom[1] = 16'hF800; rom[2] = 16'hF000; rom[3] = 16'hF800;
    drive(2'd0, 1'b1, 15'd0);
    tick();
    drive(2'd2, 1'b0, '0);
    chk("p_v0", 32'(v0), 32'd1);
    chk("p_is32", 32'(is32), 32'd1);
    chk("p_v1", 32'(v1), 32'd0);
    tick();
    drive(2'd0, 1'b0, '0);
    chk("p_buf2", 32'(buf_hpc), 32'd2);
    chk("p_is32_2", 32'(is32), 32'd1);
    tick();

    // lone prefix in slot 1, illegal issue of 2
    rom[10] = 16'hBF00; rom[11] = 16'hF000;
    drive(2'd0, 1'b1, 15'd10);
    tick();
    drive(2'd2, 1'b0, '0);
    chk("e_v1", 32'(v1), 32'd0);
    tick();
    drive(2'd0, 1'b0, '0);
    chk("e_err", 32'(err), 32'd1);
    chk("e_buf", 32'(buf_hpc), 32'd10);
    tick();

    // redirect out of HALT
    drive(2'd0, 1'b1, 15'd4);
    tick();
    drive(2'd2, 1'b0, '0);
    tick();
    drive(2'd0, 1'b1, 15'd0);
    chk("h_halted", 32'(halted), 32'd1);
    tick();
    drive(2'd0, 1'b0, '0);
    chk("h_unhalt", 32'(halted), 32'd0);
    chk("h_buf", 32'(buf_hpc), 32'd0);
    chk("h_v0", 32'(v0), 32'd1);
    chk("h_err_sticky", 32'(err), 32'd1);
    mid_reset();

    // wrap at the top of the halfword space
    rom[ROM_N-1] = 16'hBF00;
    drive(2'd0, 1'b1, 15'h7FFF);
    tick();
    drive(2'd1, 1'b0, '0);
    chk("w_addr", 32'(Rom_addr_in), 32'd0);
    chk("w_pc1", 32'(pc_1), 32'd0);
    tick();
    drive(2'd0, 1'b0, '0);
    chk("w_buf", 32'(buf_hpc), 32'd0);
    tick();

    // randomized traffic
    for (int i = 0; i < 64; i++) rom[i] = rand_hw();
    for (int i = ROM_N - 8; i < ROM_N; i++) rom[i] = rand_hw();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      if ($urandom_range(0, 19) == 0) begin
        c = 2'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 2))
          0: c = 2'd0;
          1: c = m_v0() ? (m_is32() ? 2'd2 : 2'd1) : 2'd0;
          default: c = m_v1() ? 2'd2 : (m_v0() ? (m_is32() ? 2'd2 : 2'd1) : 2'd0);
        endcase
      end
      if ($urandom_range(0, 9) == 0) begin
        tgt = ($urandom_range(0, 7) == 0) ? HW'(ROM_N - 1 - $urandom_range(0, 6))
                                          : HW'($urandom_range(0, 62));
        drive(c, 1'b1, tgt);
      end else begin
        drive(c, 1'b0, '0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
